// File: rtl/imem_prog_loader.sv
// Boot-time program loader: frames a byte stream into LE words and writes them to instruction memory.
// Latency: a word write, or the done/error status, appears the cycle after its last byte is accepted.
// Backpressure: in_ready is high in HDR/DATA/CSUM unless reload is asserted. It is low in DONE/ERROR.
//
// Ports:
//   clk, rst                  clock and synchronous active-high reset
//   reload                    1-cycle restart pulse; returns to header state and re-asserts core_rst
//   in_valid/in_data/in_ready byte stream, transfer = in_valid & in_ready
//   imem_we/imem_waddr/imem_wdata  registered instruction-memory write port (byte address)
//   core_rst/done/error       registered load status
module imem_prog_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        reload,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        imem_we,
  output logic [31:0] imem_waddr,
  output logic [31:0] imem_wdata,
  output logic        core_rst,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    S_HDR,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERROR
  } state_e;

  localparam logic [31:0] MaxWords = 32'(MAX_WORDS);

  state_e      state_q;
  logic [1:0]  byte_cnt_q;
  logic [23:0] asm_q;       // first three bytes of the current header/word, newest on top
  logic [7:0]  csum_q;
  logic [31:0] n_words_q;
  logic [31:0] word_idx_q;
  logic        imem_we_q;
  logic [31:0] imem_waddr_q;
  logic [31:0] imem_wdata_q;
  logic        core_rst_q;
  logic        done_q;
  logic        error_q;

  logic        xfer;
  logic        last_byte;
  logic [31:0] word_d;
  logic [7:0]  csum_d;

  assign in_ready  = ((state_q == S_HDR) || (state_q == S_DATA) || (state_q == S_CSUM)) && !reload;
  assign xfer      = in_valid && in_ready;
  assign last_byte = (byte_cnt_q == 2'd3);
  // Little-endian: the byte arriving now is the most significant one of the word.
  assign word_d    = {in_data, asm_q};
  assign csum_d    = csum_q ^ in_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_HDR;
      byte_cnt_q   <= 2'd0;
      asm_q        <= 24'd0;
      csum_q       <= 8'd0;
      n_words_q    <= 32'd0;
      word_idx_q   <= 32'd0;
      imem_we_q    <= 1'b0;
      imem_waddr_q <= BASE_ADDR;
      imem_wdata_q <= 32'd0;
      core_rst_q   <= 1'b1;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else if (reload) begin
      state_q      <= S_HDR;
      byte_cnt_q   <= 2'd0;
      asm_q        <= 24'd0;
      csum_q       <= 8'd0;
      n_words_q    <= 32'd0;
      word_idx_q   <= 32'd0;
      imem_we_q    <= 1'b0;
      imem_waddr_q <= BASE_ADDR;
      core_rst_q   <= 1'b1;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      imem_we_q <= 1'b0;
      case (state_q)
        S_HDR: begin
          if (xfer) begin
            csum_q     <= csum_d;
            byte_cnt_q <= byte_cnt_q + 2'd1;
            asm_q      <= {in_data, asm_q[23:8]};
            if (last_byte) begin
              n_words_q <= word_d;
              if (word_d > MaxWords) begin
                state_q <= S_ERROR;
                error_q <= 1'b1;
              end else if (word_d == 32'd0) begin
                state_q <= S_CSUM;
              end else begin
                state_q <= S_DATA;
              end
            end
          end
        end
        S_DATA: begin
          if (xfer) begin
            csum_q     <= csum_d;
            byte_cnt_q <= byte_cnt_q + 2'd1;
            asm_q      <= {in_data, asm_q[23:8]};
            if (last_byte) begin
              imem_we_q    <= 1'b1;
              imem_waddr_q <= BASE_ADDR + (word_idx_q << 2);
              imem_wdata_q <= word_d;
              word_idx_q   <= word_idx_q + 32'd1;
              // n_words_q >= 1 here, so the subtraction cannot wrap.
              if (word_idx_q == n_words_q - 32'd1) begin
                state_q <= S_CSUM;
              end
            end
          end
        end
        S_CSUM: begin
          if (xfer) begin
            if (in_data == csum_q) begin
              state_q    <= S_DONE;
              done_q     <= 1'b1;
              core_rst_q <= 1'b0;
            end else begin
              state_q <= S_ERROR;
              error_q <= 1'b1;
            end
          end
        end
        default: begin
          // DONE and ERROR are terminal until reload or rst.
        end
      endcase
    end
  end

  assign imem_we    = imem_we_q;
  assign imem_waddr = imem_waddr_q;
  assign imem_wdata = imem_wdata_q;
  assign core_rst   = core_rst_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule

// File: tb/tb_imem_prog_loader.sv
module tb_imem_prog_loader;

  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam logic [31:0] MAXW = 32'd256;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        reload = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_ready;
  logic        imem_we;
  logic [31:0] imem_waddr;
  logic [31:0] imem_wdata;
  logic        core_rst;
  logic        done;
  logic        error;

  int checks = 0;
  int errors = 0;

  // Scoreboard: expected memory writes, pushed when a frame is issued.
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  logic [31:0] frame_words[$];

  imem_prog_loader #(
    .BASE_ADDR(BASE),
    .MAX_WORDS(256)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .reload    (reload),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .imem_we   (imem_we),
    .imem_waddr(imem_waddr),
    .imem_wdata(imem_wdata),
    .core_rst  (core_rst),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (!rst && imem_we === 1'b1) begin
      if (exp_addr_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %h data %h expected no write", imem_waddr, imem_wdata);
      end else begin
        chk("write_addr", imem_waddr, exp_addr_q.pop_front());
        chk("write_data", imem_wdata, exp_data_q.pop_front());
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int w;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    w = 0;
    while (in_ready !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (in_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got in_ready %b expected 1 within 50 cycles", in_ready);
    end
    @(posedge clk);
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 8'($urandom);
    end
  endtask

  task automatic pulse_reload();
    @(negedge clk);
    reload   = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'($urandom);
    #1;
    chk("ready_during_reload", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    reload   = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("reload_ready", {31'd0, in_ready}, 32'd1);
    chk("reload_done", {31'd0, done}, 32'd0);
    chk("reload_error", {31'd0, error}, 32'd0);
    chk("reload_core_rst", {31'd0, core_rst}, 32'd1);
  endtask

  function automatic int pick_gap(input int mode);
    if (mode == 0) return 0;
    if (mode == 1) return 1;
    return int'($urandom_range(0, 2));
  endfunction

  // Reference model: frame bytes, expected writes and outcome derived from the frame rules.
  task automatic run_frame(input logic [31:0] n, input logic [7:0] bad_mask, input int gap_mode,
                           input bit use_given);
    logic [7:0] bytes[$];
    logic [7:0] x;
    logic [31:0] w;
    bit bad;
    if (!use_given) begin
      frame_words.delete();
      if (n <= MAXW) for (int k = 0; k < int'(n); k++) frame_words.push_back($urandom);
    end
    for (int i = 0; i < 4; i++) bytes.push_back(n[8*i +: 8]);
    if (n > MAXW) begin
      for (int i = 0; i < 4; i++) send_byte(bytes[i], (i == 3) ? 0 : pick_gap(gap_mode));
      @(negedge clk);
      in_valid = 1'b0;
      chk("oversize_error", {31'd0, error}, 32'd1);
      chk("oversize_done", {31'd0, done}, 32'd0);
      chk("oversize_core_rst", {31'd0, core_rst}, 32'd1);
      chk("oversize_ready", {31'd0, in_ready}, 32'd0);
      repeat (3) @(negedge clk);
      chk("oversize_error_hold", {31'd0, error}, 32'd1);
      return;
    end
    for (int k = 0; k < int'(n); k++) begin
      w = frame_words[k];
      exp_addr_q.push_back(BASE + 32'(k) * 32'd4);
      exp_data_q.push_back(w);
      for (int i = 0; i < 4; i++) bytes.push_back(w[8*i +: 8]);
    end
    x = 8'd0;
    foreach (bytes[i]) x = x ^ bytes[i];
    bad = (bad_mask != 8'd0);
    bytes.push_back(x ^ bad_mask);
    foreach (bytes[i]) send_byte(bytes[i], (i == bytes.size() - 1) ? 0 : pick_gap(gap_mode));
    @(negedge clk);
    in_valid = 1'b0;
    chk("frame_done", {31'd0, done}, bad ? 32'd0 : 32'd1);
    chk("frame_error", {31'd0, error}, bad ? 32'd1 : 32'd0);
    chk("frame_core_rst", {31'd0, core_rst}, bad ? 32'd1 : 32'd0);
    chk("frame_ready", {31'd0, in_ready}, 32'd0);
    chk("writes_pending", 32'(exp_addr_q.size()), 32'd0);
    repeat (2) @(negedge clk);
    chk("status_hold", {30'd0, done, error}, bad ? 32'd1 : 32'd2);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation time limit expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_we", {31'd0, imem_we}, 32'd0);
    chk("rst_waddr", imem_waddr, BASE);
    chk("rst_wdata", imem_wdata, 32'd0);
    chk("rst_core_rst", {31'd0, core_rst}, 32'd1);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_error", {31'd0, error}, 32'd0);

    // One-word load: 01 00 00 00 93 00 50 00 C2
    frame_words = '{32'h0050_0093};
    run_frame(32'd1, 8'h00, 0, 1'b1);
    pulse_reload();

    // Empty frame
    run_frame(32'd0, 8'h00, 0, 1'b0);
    pulse_reload();

    // Oversize header 257
    run_frame(32'd257, 8'h00, 0, 1'b0);
    pulse_reload();

    // Bad checksum on the one-word frame (C3 instead of C2)
    frame_words = '{32'h0050_0093};
    run_frame(32'd1, 8'h01, 0, 1'b1);
    pulse_reload();

    // Gapped two-word frame
    run_frame(32'd2, 8'h00, 1, 1'b0);
    pulse_reload();

    // Reload mid-DATA after two data bytes; partial word must never be written
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    pulse_reload();
    run_frame(32'd2, 8'h00, 0, 1'b0);
    pulse_reload();

    // Largest accepted frame
    run_frame(MAXW, 8'h00, 0, 1'b0);
    pulse_reload();

    // Huge header
    run_frame(32'hFFFF_FFFF, 8'h00, 0, 1'b0);
    pulse_reload();

    // Randomized frames
    for (int f = 0; f < 20; f++) begin
      logic [31:0] n;
      logic [7:0]  mask;
      n = 32'($urandom_range(0, 6));
      if ($urandom_range(0, 7) == 0) n = MAXW + 32'd1 + 32'($urandom_range(0, 1000));
      mask = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      run_frame(n, mask, int'($urandom_range(0, 2)), 1'b0);
      pulse_reload();
    end

    repeat (3) @(negedge clk);
    chk("final_writes_pending", 32'(exp_addr_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
